// File: rtl/out_writeback_packer_if.sv
// Bus bundle for the output write-back packer: job control, accumulator stream, SRAM write port.
// Write-request encodings are shared by the packer and anything that watches the SRAM bus.
`ifndef WRITE_ENB
`define WRITE_ENB 4'b1111
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 4'b0000
`endif

interface out_writeback_packer_if #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 18,
   parameter int CNT_W  = 20
);
   logic              start_i;
   logic [ADDR_W-1:0] base_addr_i;
   logic [CNT_W-1:0]  num_elems_i;
   logic [4:0]        shift_i;
   logic              relu_en_i;
   logic              acc_valid_i;
   logic [ACC_W-1:0]  acc_data_i;
   logic              acc_ready_o;
   logic              busy_o;
   logic              done_o;
   logic              sram_cs_o;
   logic              sram_oe_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic [3:0]        sram_wreq_o;
   logic [31:0]       sram_wdata_o;

   // master: the packer, which owns the SRAM bus during a job
   modport master (
      input  start_i, base_addr_i, num_elems_i, shift_i, relu_en_i, acc_valid_i, acc_data_i,
      output acc_ready_o, busy_o, done_o, sram_cs_o, sram_oe_o, sram_addr_o, sram_wreq_o,
             sram_wdata_o
   );
   modport slave (
      output start_i, base_addr_i, num_elems_i, shift_i, relu_en_i, acc_valid_i, acc_data_i,
      input  acc_ready_o, busy_o, done_o, sram_cs_o, sram_oe_o, sram_addr_o, sram_wreq_o,
             sram_wdata_o
   );
endinterface

// File: rtl/out_writeback_packer.sv
// Requantises signed accumulator results to int8, packs four per word (little-endian)
// and writes the words sequentially to the output SRAM, one write per filled/final word.
`ifndef WRITE_ENB
`define WRITE_ENB 4'b1111
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 4'b0000
`endif

module out_writeback_packer #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 18,
   parameter int CNT_W  = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   out_writeback_packer_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic signed [ACC_W:0] QMAX = 127;
   localparam logic signed [ACC_W:0] QMIN = -128;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base_r, word_idx, addr_r;
   logic [CNT_W-1:0]  n_r, acc_cnt;
   logic [4:0]        shift_r;
   logic              relu_r;
   logic [3:0][7:0]   pack, pack_nxt;
   logic [31:0]       wdata_r;
   logic              cs_r;
   logic [3:0]        wreq_r;
   logic              ready, accept, flush;
   logic [7:0]        q;

   // Rounding shift in one extra bit so adding the half-LSB never overflows.
   function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc, input logic [4:0] sh,
                                          input logic relu);
      logic signed [ACC_W:0] t, rnd, r;
      rnd = (sh != 5'd0) ? ((ACC_W+1)'(1) << (sh - 5'd1)) : '0;
      t   = $signed({acc[ACC_W-1], acc}) + rnd;
      r   = t >>> sh;
      if (relu && r < 0) r = '0;
      if (r > QMAX)      return 8'h7F;
      else if (r < QMIN) return 8'h80;
      else               return r[7:0];
   endfunction

   assign ready  = (state == RUN) && (acc_cnt < n_r);
   assign accept = ready && bus.acc_valid_i;
   assign q      = requant(bus.acc_data_i, shift_r, relu_r);
   assign flush  = (acc_cnt[1:0] == 2'd3) || ((acc_cnt + CNT_W'(1)) == n_r);

   always_comb begin
      pack_nxt                = pack;
      pack_nxt[acc_cnt[1:0]]  = q;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_i) state_nxt = RUN;
         // The last write is on the bus when every element has been taken.
         RUN:     if (n_r == '0 || (cs_r && acc_cnt == n_r)) state_nxt = DONE;
         DONE:    if (!bus.start_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         base_r   <= '0;
         n_r      <= '0;
         shift_r  <= '0;
         relu_r   <= 1'b0;
         acc_cnt  <= '0;
         word_idx <= '0;
         pack     <= '0;
         addr_r   <= '0;
         wdata_r  <= '0;
         cs_r     <= 1'b0;
         wreq_r   <= `WRITE_DIS;
      end else begin
         state  <= state_nxt;
         cs_r   <= 1'b0;
         wreq_r <= `WRITE_DIS;
         if (state == IDLE && bus.start_i) begin
            base_r   <= bus.base_addr_i;
            n_r      <= bus.num_elems_i;
            shift_r  <= bus.shift_i;
            relu_r   <= bus.relu_en_i;
            acc_cnt  <= '0;
            word_idx <= '0;
            pack     <= '0;
         end
         if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (flush) begin
               wdata_r  <= pack_nxt;
               pack     <= '0;
               cs_r     <= 1'b1;
               wreq_r   <= `WRITE_ENB;
               addr_r   <= base_r + word_idx;
               word_idx <= word_idx + ADDR_W'(1);
            end else begin
               pack <= pack_nxt;
            end
         end
      end
   end

   assign bus.acc_ready_o  = ready;
   assign bus.busy_o       = (state == RUN);
   assign bus.done_o       = (state == DONE);
   assign bus.sram_cs_o    = cs_r;
   assign bus.sram_oe_o    = 1'b0;
   assign bus.sram_addr_o  = addr_r;
   assign bus.sram_wreq_o  = wreq_r;
   assign bus.sram_wdata_o = wdata_r;
endmodule
